// File: rtl/mutton_price_pkg.sv
`default_nettype none
// ============================================================================
// Package : mutton_price_pkg - item codes, price table and encoder FSM states
// Rev     : 1.0
// ============================================================================
package mutton_price_pkg;

  typedef enum logic [2:0] {
    ITEM_MEAT   = 3'b000,
    ITEM_LIVER  = 3'b101,
    ITEM_SPLINE = 3'b110,
    ITEM_BONE   = 3'b111
  } item_code_e;

  localparam int unsigned PRICE_MEAT   = 1000;
  localparam int unsigned PRICE_LIVER  = 600;
  localparam int unsigned PRICE_SPLINE = 200;
  localparam int unsigned PRICE_BONE   = 100;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } enc_state_e;

endpackage
`default_nettype wire

// File: rtl/mutton_price_lookup.sv
`default_nettype none
// ============================================================================
// Module : mutton_price_lookup - combinational price -> {hit, item code}
// Rev    : 1.0
// ============================================================================
module mutton_price_lookup
  import mutton_price_pkg::*;
#(
  parameter int PRICE_W = 11
) (
  input  logic [PRICE_W-1:0] price,
  output logic               hit,
  output logic [2:0]         code
);

  // An unmatched price is a legal miss: code stays ITEM_MEAT, hit stays low.
  always_comb begin
    hit  = 1'b0;
    code = ITEM_MEAT;
    unique0 case (price)
      PRICE_W'(PRICE_MEAT): begin
        hit  = 1'b1;
        code = ITEM_MEAT;
      end
      PRICE_W'(PRICE_LIVER): begin
        hit  = 1'b1;
        code = ITEM_LIVER;
      end
      PRICE_W'(PRICE_SPLINE): begin
        hit  = 1'b1;
        code = ITEM_SPLINE;
      end
      PRICE_W'(PRICE_BONE): begin
        hit  = 1'b1;
        code = ITEM_BONE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mutton_price_encoder.sv
`default_nettype none
// ============================================================================
// Module : mutton_price_encoder - price stream -> registered item-code stream
//          with saturating bill total; MUTTON_ENC_STATS_EN adds hit/miss counts
// Rev    : 1.0
// ============================================================================
module mutton_price_encoder
  import mutton_price_pkg::*;
#(
  parameter int PRICE_W = 11,
  parameter int TOTAL_W = 16,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PRICE_W-1:0] in_price,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2:0]         out_code,
  output logic               out_hit,
  input  logic               clr_total,
  output logic [TOTAL_W-1:0] total,
  output logic [CNT_W-1:0]   hit_cnt,
  output logic [CNT_W-1:0]   miss_cnt
);

  localparam int SUM_W = ((TOTAL_W > PRICE_W) ? TOTAL_W : PRICE_W) + 1;

  enc_state_e         state;
  enc_state_e         state_next;
  logic               accept;
  logic               lk_hit;
  logic [2:0]         lk_code;
  logic [2:0]         code_q;
  logic               hit_q;
  logic [TOTAL_W-1:0] total_q;
  logic [TOTAL_W-1:0] total_base;
  logic [TOTAL_W-1:0] total_next;
  logic [SUM_W-1:0]   sum;

  mutton_price_lookup #(.PRICE_W(PRICE_W)) u_lookup (
    .price (in_price),
    .hit   (lk_hit),
    .code  (lk_code)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_EMPTY: if (accept) state_next = ST_FULL;
      ST_FULL:  if (out_ready && !accept) state_next = ST_EMPTY;
      default:  state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == ST_FULL);
    in_ready  = (state == ST_EMPTY) || out_ready;
  end

  assign accept   = in_valid && in_ready;
  assign out_code = code_q;
  assign out_hit  = hit_q;
  assign total    = total_q;

  // Clear takes effect before the add, so clear + matched accept yields the price.
  always_comb begin
    total_base = clr_total ? '0 : total_q;
    sum        = SUM_W'(total_base) + SUM_W'(in_price);
    total_next = total_base;
    if (accept && lk_hit) begin
      total_next = (|sum[SUM_W-1:TOTAL_W]) ? '1 : sum[TOTAL_W-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      code_q  <= ITEM_MEAT;
      hit_q   <= 1'b0;
      total_q <= '0;
    end else begin
      total_q <= total_next;
      if (accept) begin
        code_q <= lk_code;
        hit_q  <= lk_hit;
      end
    end
  end

`ifdef MUTTON_ENC_STATS_EN
  logic [CNT_W-1:0] hit_cnt_q;
  logic [CNT_W-1:0] miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (accept) begin
      if (lk_hit && (hit_cnt_q != '1)) hit_cnt_q <= hit_cnt_q + CNT_W'(1);
      if (!lk_hit && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + CNT_W'(1);
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mutton_price_encoder.sv
`default_nettype none
// ============================================================================
// Module : tb_mutton_price_encoder - table, directed and random checks
// Rev    : 1.0
// ============================================================================
module tb_mutton_price_encoder;

  localparam int PRICE_W = 11;
  localparam int TOTAL_W = 16;
  localparam int CNT_W   = 8;
  localparam longint TMAX = (64'd1 << TOTAL_W) - 1;
  localparam longint CMAX = (64'd1 << CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [PRICE_W-1:0] in_price;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_code;
  logic               out_hit;
  logic               clr_total;
  logic [TOTAL_W-1:0] total;
  logic [CNT_W-1:0]   hit_cnt;
  logic [CNT_W-1:0]   miss_cnt;

  // narrow-total instance for the saturation case
  logic               s_rst_n;
  logic               s_in_valid;
  logic               s_in_ready;
  logic [PRICE_W-1:0] s_in_price;
  logic               s_out_valid;
  logic               s_out_ready;
  logic [2:0]         s_out_code;
  logic               s_out_hit;
  logic               s_clr_total;
  logic [10:0]        s_total;
  logic [CNT_W-1:0]   s_hit_cnt;
  logic [CNT_W-1:0]   s_miss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic   m_valid;
  logic   m_hit;
  logic [2:0] m_code;
  longint m_tot;
  longint m_hc;
  longint m_mc;

  typedef struct {
    logic        v;
    logic [10:0] p;
    logic        r;
    logic        c;
    logic        ev;
    logic [2:0]  ecode;
    logic        ehit;
    int          etot;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  mutton_price_encoder #(.PRICE_W(PRICE_W), .TOTAL_W(TOTAL_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_price  (in_price),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_hit   (out_hit),
    .clr_total (clr_total),
    .total     (total),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  mutton_price_encoder #(.PRICE_W(PRICE_W), .TOTAL_W(11), .CNT_W(CNT_W)) dut_sat (
    .clk       (clk),
    .rst_n     (s_rst_n),
    .in_valid  (s_in_valid),
    .in_ready  (s_in_ready),
    .in_price  (s_in_price),
    .out_valid (s_out_valid),
    .out_ready (s_out_ready),
    .out_code  (s_out_code),
    .out_hit   (s_out_hit),
    .clr_total (s_clr_total),
    .total     (s_total),
    .hit_cnt   (s_hit_cnt),
    .miss_cnt  (s_miss_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {hit, code} straight from the price table
  function automatic logic [3:0] ref_lookup(input logic [10:0] p);
    if (p == 11'd1000) return 4'b1_000;
    if (p == 11'd600)  return 4'b1_101;
    if (p == 11'd200)  return 4'b1_110;
    if (p == 11'd100)  return 4'b1_111;
    return 4'b0_000;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, check outputs.
  task automatic step(input logic v, input logic [10:0] p, input logic r, input logic c);
    logic       acc;
    logic [3:0] lk;
    in_valid  = v;
    in_price  = p;
    out_ready = r;
    clr_total = c;
    #1;
    if (rst_n) chk("in_ready", in_ready, (!m_valid || r));
    acc = rst_n && v && (!m_valid || r);
    lk  = ref_lookup(p);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_tot   = 0;
      m_hc    = 0;
      m_mc    = 0;
    end else begin
      if (c) m_tot = 0;
      if (acc) begin
        m_valid = 1'b1;
        m_hit   = lk[3];
        m_code  = lk[2:0];
        if (lk[3]) begin
          m_tot = m_tot + p;
          if (m_tot > TMAX) m_tot = TMAX;
        end
`ifdef MUTTON_ENC_STATS_EN
        if (lk[3]) begin
          if (m_hc < CMAX) m_hc++;
        end else begin
          if (m_mc < CMAX) m_mc++;
        end
`endif
      end else if (r) begin
        m_valid = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_code", out_code, m_code);
      chk("out_hit", out_hit, m_hit);
    end
    chk("total", total, m_tot);
    chk("hit_cnt", hit_cnt, m_hc);
    chk("miss_cnt", miss_cnt, m_mc);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] rp;
    tbl[0] = '{1'b1, 11'd1000, 1'b1, 1'b0, 1'b1, 3'b000, 1'b1, 1000};
    tbl[1] = '{1'b1, 11'd600,  1'b1, 1'b0, 1'b1, 3'b101, 1'b1, 1600};
    tbl[2] = '{1'b1, 11'd200,  1'b1, 1'b0, 1'b1, 3'b110, 1'b1, 1800};
    tbl[3] = '{1'b1, 11'd100,  1'b1, 1'b0, 1'b1, 3'b111, 1'b1, 1900};
    tbl[4] = '{1'b1, 11'd750,  1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1900};
    tbl[5] = '{1'b0, 11'd0,    1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 1900};

    m_valid = 1'b0; m_hit = 1'b0; m_code = 3'b000;
    m_tot = 0; m_hc = 0; m_mc = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_price = '0; out_ready = 1'b0; clr_total = 1'b0;
    s_rst_n = 1'b0; s_in_valid = 1'b0; s_in_price = '0; s_out_ready = 1'b1; s_clr_total = 1'b0;
    @(posedge clk); #1;

    // reset state
    step(1'b0, 11'd0, 1'b1, 1'b0);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_total", total, 0);
    rst_n   = 1'b1;
    s_rst_n = 1'b1;

    // back-to-back table prices, then a miss, then idle
    for (int i = 0; i < 6; i++) begin
      step(tbl[i].v, tbl[i].p, tbl[i].r, tbl[i].c);
      chk("tbl_out_valid", out_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk("tbl_out_code", out_code, tbl[i].ecode);
        chk("tbl_out_hit", out_hit, tbl[i].ehit);
      end
      chk("tbl_total", total, tbl[i].etot);
    end
`ifdef MUTTON_ENC_STATS_EN
    chk("miss_cnt_750", miss_cnt, 1);
    chk("hit_cnt_4", hit_cnt, 4);
`endif

    // backpressure: 600 held for 3 cycles while 200 waits
    step(1'b1, 11'd600, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 11'd200, 1'b0, 1'b0);
      chk("bp_held_code", out_code, 3'b101);
      chk("bp_in_ready_low", in_ready, 1'b0);
    end
    step(1'b1, 11'd200, 1'b1, 1'b0);
    chk("bp_release_code", out_code, 3'b110);
    chk("bp_release_valid", out_valid, 1'b1);
    step(1'b0, 11'd0, 1'b1, 1'b0);
    chk("bp_total", total, 1900 + 800);

    // clear in the same cycle as a matched accept
    rst_n = 1'b0;
    step(1'b0, 11'd0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 11'd200, 1'b1, 1'b0);
    step(1'b1, 11'd100, 1'b1, 1'b0);
    chk("pre_clr_total", total, 300);
    step(1'b1, 11'd1000, 1'b1, 1'b1);
    chk("clr_same_cycle_total", total, 1000);
    step(1'b0, 11'd0, 1'b1, 1'b1);
    chk("clr_alone_total", total, 0);

    // reset while FULL holding 111
    step(1'b1, 11'd100, 1'b1, 1'b0);
    step(1'b0, 11'd0, 1'b0, 1'b0);
    chk("hold_bone_code", out_code, 3'b111);
    rst_n = 1'b0;
    step(1'b0, 11'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_total", total, 0);
    chk("midrst_hit_cnt", hit_cnt, 0);
    chk("midrst_miss_cnt", miss_cnt, 0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 5))
        0: rp = 11'd1000;
        1: rp = 11'd600;
        2: rp = 11'd200;
        3: rp = 11'd100;
        default: rp = 11'($urandom_range(0, 2047));
      endcase
      step(($urandom_range(0, 3) != 0), rp, ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 31) == 0));
    end

    // saturation with an 11-bit total
    in_valid     = 1'b0;
    s_in_valid   = 1'b1;
    s_in_price   = 11'd1000;
    s_out_ready  = 1'b1;
    @(posedge clk); #1;
    chk("sat_total_1", s_total, 1000);
    @(posedge clk); #1;
    chk("sat_total_2", s_total, 2000);
    @(posedge clk); #1;
    chk("sat_total_3", s_total, 2047);
    @(posedge clk); #1;
    chk("sat_total_4", s_total, 2047);
    s_in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
